// File: rtl/axil_reg_bridge.sv
// AXI4-Lite responder that turns each AXI transaction into one REG_BUS access; one outstanding op per direction.
// Define AXIL_RD_TIMEOUT_EN to answer SLVERR/0xDEADBEEF when rvld does not arrive within RD_TIMEOUT cycles.
module axil_reg_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic [2:0]              s_axil_awprot,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [2:0]              s_axil_arprot,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  output logic                    m_reg_wren,
  output logic [ADDR_WIDTH-1:0]   m_reg_waddr,
  output logic [DATA_WIDTH-1:0]   m_reg_wdata,
  output logic [DATA_WIDTH/8-1:0] m_reg_wstrb,
  output logic                    m_reg_rden,
  output logic [ADDR_WIDTH-1:0]   m_reg_raddr,
  input  logic [DATA_WIDTH-1:0]   m_reg_rdata,
  input  logic                    m_reg_rvld
);

  localparam int LSB = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << LSB) - 1);

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_t;

  w_state_t w_state;
  r_state_t r_state;
  logic     aw_got;
  logic     w_got;
  logic     aw_hs;
  logic     w_hs;
  logic     ar_hs;

  // Protection bits carry no meaning for the register file.
  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, (RD_TIMEOUT != 0)};

  assign aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_hs  = s_axil_wvalid && s_axil_wready;
  assign ar_hs = s_axil_arvalid && s_axil_arready;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state        <= W_IDLE;
      aw_got         <= 1'b0;
      w_got          <= 1'b0;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= 2'b00;
      m_reg_wren     <= 1'b0;
      m_reg_waddr    <= '0;
      m_reg_wdata    <= '0;
      m_reg_wstrb    <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          // AW and W are collected independently; each ready drops after its own beat.
          if (aw_hs) begin
            aw_got         <= 1'b1;
            s_axil_awready <= 1'b0;
            m_reg_waddr    <= s_axil_awaddr & ALIGN_MASK;
          end else if (!aw_got) begin
            s_axil_awready <= 1'b1;
          end
          if (w_hs) begin
            w_got         <= 1'b1;
            s_axil_wready <= 1'b0;
            m_reg_wdata   <= s_axil_wdata;
            m_reg_wstrb   <= s_axil_wstrb;
          end else if (!w_got) begin
            s_axil_wready <= 1'b1;
          end
          if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            m_reg_wren <= 1'b1;
            w_state    <= W_ISSUE;
          end
        end
        W_ISSUE: begin
          m_reg_wren    <= 1'b0;
          s_axil_bvalid <= 1'b1;
          s_axil_bresp  <= 2'b00;
          w_state       <= W_RESP;
        end
        W_RESP: begin
          if (s_axil_bready) begin
            s_axil_bvalid  <= 1'b0;
            aw_got         <= 1'b0;
            w_got          <= 1'b0;
            s_axil_awready <= 1'b1;
            s_axil_wready  <= 1'b1;
            w_state        <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

`ifdef AXIL_RD_TIMEOUT_EN
  localparam int CNT_W = ($clog2(RD_TIMEOUT + 1) > 8) ? $clog2(RD_TIMEOUT + 1) : 8;
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = {(DATA_WIDTH / 32){32'hDEAD_BEEF}};
  logic [CNT_W-1:0] rd_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= R_IDLE;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rresp   <= 2'b00;
      s_axil_rdata   <= '0;
      m_reg_rden     <= 1'b0;
      m_reg_raddr    <= '0;
`ifdef AXIL_RD_TIMEOUT_EN
      rd_cnt         <= '0;
`endif
    end else begin
      case (r_state)
        R_IDLE: begin
`ifdef AXIL_RD_TIMEOUT_EN
          rd_cnt <= '0;
`endif
          if (ar_hs) begin
            s_axil_arready <= 1'b0;
            m_reg_raddr    <= s_axil_araddr & ALIGN_MASK;
            m_reg_rden     <= 1'b1;
            r_state        <= R_ISSUE;
          end else begin
            s_axil_arready <= 1'b1;
          end
        end
        // rvld is honoured in the issue cycle too, which skips R_WAIT entirely.
        R_ISSUE, R_WAIT: begin
          m_reg_rden <= 1'b0;
          if (m_reg_rvld) begin
            s_axil_rdata  <= m_reg_rdata;
            s_axil_rresp  <= 2'b00;
            s_axil_rvalid <= 1'b1;
            r_state       <= R_RESP;
          end
`ifdef AXIL_RD_TIMEOUT_EN
          else if (rd_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
            s_axil_rdata  <= ERR_DATA;
            s_axil_rresp  <= 2'b10;
            s_axil_rvalid <= 1'b1;
            r_state       <= R_RESP;
          end else begin
            rd_cnt  <= rd_cnt + 1'b1;
            r_state <= R_WAIT;
          end
`else
          else begin
            r_state <= R_WAIT;
          end
`endif
        end
        R_RESP: begin
          if (s_axil_rready) begin
            s_axil_rvalid  <= 1'b0;
            s_axil_arready <= 1'b1;
            r_state        <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Bench for axil_reg_bridge: directed vector table, hand-written corner sequences and a random phase
// checked against a transaction-level register-file model.
`timescale 1ns/1ps
module tb_axil_reg_bridge;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int RD_TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] s_axil_awaddr = '0;
  logic [2:0]    s_axil_awprot = '0;
  logic          s_axil_awvalid = 1'b0;
  logic          s_axil_awready;
  logic [DW-1:0] s_axil_wdata = '0;
  logic [3:0]    s_axil_wstrb = '0;
  logic          s_axil_wvalid = 1'b0;
  logic          s_axil_wready;
  logic [1:0]    s_axil_bresp;
  logic          s_axil_bvalid;
  logic          s_axil_bready = 1'b0;
  logic [AW-1:0] s_axil_araddr = '0;
  logic [2:0]    s_axil_arprot = '0;
  logic          s_axil_arvalid = 1'b0;
  logic          s_axil_arready;
  logic [DW-1:0] s_axil_rdata;
  logic [1:0]    s_axil_rresp;
  logic          s_axil_rvalid;
  logic          s_axil_rready = 1'b0;
  logic          m_reg_wren;
  logic [AW-1:0] m_reg_waddr;
  logic [DW-1:0] m_reg_wdata;
  logic [3:0]    m_reg_wstrb;
  logic          m_reg_rden;
  logic [AW-1:0] m_reg_raddr;
  logic [DW-1:0] m_reg_rdata = '0;
  logic          m_reg_rvld = 1'b0;

  axil_reg_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(RD_TO)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .m_reg_wren(m_reg_wren), .m_reg_waddr(m_reg_waddr), .m_reg_wdata(m_reg_wdata),
    .m_reg_wstrb(m_reg_wstrb), .m_reg_rden(m_reg_rden), .m_reg_raddr(m_reg_raddr),
    .m_reg_rdata(m_reg_rdata), .m_reg_rvld(m_reg_rvld)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wren_cyc = -1;
  int rden_cyc = -2;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register contents the downstream block reports for locations never written.
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Downstream register file driven by the DUT's REG_BUS outputs.
  logic [31:0] smem [logic [31:0]];
  int          rd_lat = 0;
  bit          rd_mute = 1'b0;
  bit          force_rvld = 1'b0;
  logic [31:0] force_rdata = '0;
  bit          pend = 1'b0;
  int          cd = 0;
  logic [31:0] ra = '0;

  function automatic logic [31:0] srd(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    bit fire;
    #2;
    fire = 1'b0;
    if (rst) pend = 1'b0;
    if (m_reg_wren) smem[m_reg_waddr] = merge(srd(m_reg_waddr), m_reg_wdata, m_reg_wstrb);
    if (m_reg_rden) begin
      pend = 1'b1;
      cd   = rd_lat;
      ra   = m_reg_raddr;
    end
    if (pend) chk("raddr_stable", m_reg_raddr, ra);
    if (pend && rd_mute) pend = 1'b0;
    if (pend) begin
      if (cd == 0) begin
        fire = 1'b1;
        pend = 1'b0;
      end else begin
        cd--;
      end
    end
    m_reg_rvld  = fire || force_rvld;
    m_reg_rdata = force_rvld ? force_rdata : (fire ? srd(ra) : 32'h0);
  end

  // Transaction-level reference: what the register at each aligned address should hold.
  logic [31:0] rmem [logic [31:0]];

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_val(a);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    rmem[a] = merge(model_read(a), d, s);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, input logic [31:0] exp_waddr);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_h, w_h;
    int t = 0;
    while (!(aw_done && w_done)) begin
      s_axil_awaddr  = addr;
      s_axil_awvalid = !aw_done && (t >= aw_dly);
      s_axil_wdata   = data;
      s_axil_wstrb   = strb;
      s_axil_wvalid  = !w_done && (t >= w_dly);
      chk("no_early_wren", m_reg_wren, 1'b0);
      if (aw_done) chk("awready_drop", s_axil_awready, 1'b0);
      if (w_done)  chk("wready_drop", s_axil_wready, 1'b0);
      aw_h = s_axil_awvalid && s_axil_awready;
      w_h  = s_axil_wvalid && s_axil_wready;
      tick();
      t++;
      if (aw_h) aw_done = 1'b1;
      if (w_h)  w_done  = 1'b1;
      if (t > 40) begin
        chk("write_hs_timeout", 1'b1, 1'b0);
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        return;
      end
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    wren_cyc = cyc;
    chk("wren_pulse", m_reg_wren, 1'b1);
    chk("waddr", m_reg_waddr, exp_waddr);
    chk("wdata", m_reg_wdata, data);
    chk("wstrb", m_reg_wstrb, strb);
    tick();
    chk("wren_one_cycle", m_reg_wren, 1'b0);
    chk("bvalid", s_axil_bvalid, 1'b1);
    chk("bresp", s_axil_bresp, 2'b00);
    for (int i = 0; i < b_dly; i++) begin
      tick();
      chk("bvalid_hold", {s_axil_bvalid, s_axil_bresp}, 3'b100);
      chk("aw_w_ready_hold", {s_axil_awready, s_axil_wready}, 2'b00);
    end
    s_axil_bready = 1'b1;
    tick();
    s_axil_bready = 1'b0;
    chk("bvalid_clear", s_axil_bvalid, 1'b0);
    chk("aw_w_ready_back", {s_axil_awready, s_axil_wready}, 2'b11);
  endtask

  // lat < 0 means the register block never answers (timeout case).
  task automatic axi_read(input logic [31:0] addr, input int lat, input int r_dly,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp, input logic [31:0] exp_raddr);
    int t = 0;
    int exp_v;
    rd_lat  = (lat < 0) ? 0 : lat;
    rd_mute = (lat < 0);
    s_axil_araddr  = addr;
    s_axil_arvalid = 1'b1;
    while (!s_axil_arready) begin
      tick();
      t++;
      if (t > 40) begin
        chk("read_ar_timeout", 1'b1, 1'b0);
        s_axil_arvalid = 1'b0;
        return;
      end
    end
    tick();
    s_axil_arvalid = 1'b0;
    rden_cyc = cyc;
    chk("rden_pulse", m_reg_rden, 1'b1);
    chk("raddr", m_reg_raddr, exp_raddr);
    chk("arready_drop", s_axil_arready, 1'b0);
    exp_v = cyc + ((lat < 0) ? RD_TO : lat + 1);
    t = 0;
    while (!s_axil_rvalid) begin
      tick();
      t++;
      if (t > 100) begin
        chk("read_r_timeout", 1'b1, 1'b0);
        return;
      end
    end
    chk("rvalid_latency", cyc, exp_v);
    chk("rdata", s_axil_rdata, exp_data);
    chk("rresp", s_axil_rresp, exp_resp);
    for (int i = 0; i < r_dly; i++) begin
      force_rdata = 32'h1234_5678;
      force_rvld  = (lat < 0) && (i == 0);
      tick();
      force_rvld = 1'b0;
      chk("r_hold", {s_axil_rvalid, s_axil_rresp, s_axil_rdata}, {1'b1, exp_resp, exp_data});
      chk("arready_hold", s_axil_arready, 1'b0);
    end
    s_axil_rready = 1'b1;
    tick();
    s_axil_rready = 1'b0;
    chk("rvalid_clear", s_axil_rvalid, 1'b0);
    chk("arready_back", s_axil_arready, 1'b1);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          d1;
    int          d2;
    int          hold;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;

    // writes: d1=aw delay, d2=w delay, hold=bready delay; reads: d1=rvld latency, hold=rready delay
    vecs[0] = '{1'b1, 32'h0000_0013, 32'hA5A5_1234, 4'hF, 0, 0, 0, 32'h0000_0010, 32'h0};
    vecs[1] = '{1'b1, 32'h0000_0020, 32'hCAFE_0001, 4'hF, 2, 0, 5, 32'h0000_0020, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 1, 0, 0, 32'h0000_0010, 32'hA5A5_1234};
    vecs[3] = '{1'b1, 32'h0000_0011, 32'hFFFF_FFFF, 4'h5, 0, 3, 1, 32'h0000_0010, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0013, 32'h0, 4'h0, 0, 0, 2, 32'h0000_0010, 32'hA5FF_12FF};
    vecs[5] = '{1'b0, 32'h0000_0024, 32'h0, 4'h0, 3, 0, 0, 32'h0000_0024, 32'h1122_3344};
    vecs[6] = '{1'b0, 32'h0000_0027, 32'h0, 4'h0, 0, 0, 1, 32'h0000_0024, 32'h1122_3344};
    vecs[7] = '{1'b0, 32'h0000_0020, 32'h0, 4'h0, 15, 0, 0, 32'h0000_0020, 32'hCAFE_0001};
    vecs[8] = '{1'b1, 32'hFFFF_FFFE, 32'h0BAD_F00D, 4'hC, 0, 0, 0, 32'hFFFF_FFFC, 32'h0};
    vecs[9] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 2, 0, 3, 32'hFFFF_FFFC, 32'h0BAD_0003};
    smem[32'h24] = 32'h1122_3344;

    tick();
    tick();
    chk("reset_ctrl", {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid,
                       s_axil_bresp, s_axil_rresp, m_reg_wren, m_reg_rden}, 13'h0);
    chk("reset_data", {s_axil_rdata, m_reg_wdata}, 64'h0);
    chk("reset_addr", {m_reg_waddr, m_reg_raddr}, 64'h0);
    chk("reset_wstrb", m_reg_wstrb, 4'h0);
    rst = 1'b0;
    chk("ready_low_at_release", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b000);
    tick();
    chk("ready_after_reset", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr)
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].d1, vecs[i].d2, vecs[i].hold, vecs[i].exp_addr);
      else
        axi_read(vecs[i].addr, vecs[i].d1, vecs[i].hold, vecs[i].exp_data, 2'b00, vecs[i].exp_addr);
    end

    // Concurrent write 0x08 and read 0x0C with a slow rready.
    fork
      axi_write(32'h08, 32'h600D_0008, 4'hF, 0, 0, 0, 32'h08);
      axi_read(32'h0C, 1, 4, 32'h5A56_FFF3, 2'b00, 32'h0C);
    join
    chk("concurrent_issue_cycle", wren_cyc, rden_cyc);
    axi_read(32'h08, 0, 0, 32'h600D_0008, 2'b00, 32'h08);

    // Reset while the write waits in W_RESP and the read in R_WAIT.
    rd_mute = 1'b1;
    s_axil_awaddr = 32'h30; s_axil_wdata = 32'h7777_0030; s_axil_wstrb = 4'hF; s_axil_araddr = 32'h30;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    tick();
    chk("pre_rst_state", {s_axil_bvalid, s_axil_rvalid}, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_outputs", {s_axil_bvalid, s_axil_rvalid, s_axil_awready, s_axil_arready, m_reg_wren, m_reg_rden}, 6'h0);
    chk("rst_mid_raddr", m_reg_raddr, 32'h0);
    rd_mute = 1'b0;
    s_axil_bready = 1'b1;
    s_axil_rready = 1'b1;
    tick();
    chk("rst_mid_ready_back", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
    for (int i = 0; i < 5; i++) begin
      chk("no_resp_after_rst", {s_axil_bvalid, s_axil_rvalid}, 2'b00);
      tick();
    end
    s_axil_bready = 1'b0;
    s_axil_rready = 1'b0;
    axi_read(32'h24, 2, 0, 32'h1122_3344, 2'b00, 32'h24);

`ifdef AXIL_RD_TIMEOUT_EN
    axi_read(32'h24, -1, 2, 32'hDEAD_BEEF, 2'b10, 32'h24);
    rd_mute = 1'b0;
    axi_read(32'h24, 1, 0, 32'h1122_3344, 2'b00, 32'h24);
`else
    axi_read(32'h24, 30, 1, 32'h1122_3344, 2'b00, 32'h24);
`endif

    // Random traffic against the reference register model.
    for (int n = 0; n < 60; n++) begin
      a = 32'h40 + $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), a & ~32'h3);
        model_write(a & ~32'h3, d, s);
      end else begin
        axi_read(a, $urandom_range(0, 6), $urandom_range(0, 3), model_read(a & ~32'h3), 2'b00, a & ~32'h3);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_reg_bridge.md
# axil_reg_bridge

AXI4-Lite responder that terminates the PS/host AXI4-Lite master port and converts each transaction into a single REG_BUS master access toward the RFSoC register file. Write and read channels are handled independently, one outstanding transaction per direction. It sits between the AXI interconnect and the register block that drives the RFSOC_REG control signals.

## Interface
- ADDR_WIDTH, 32, address width on both buses
- DATA_WIDTH, 32, data width on both buses; must be 32 or 64
- RD_TIMEOUT, 255, cycles to wait for rvld before a forced error response (only with the timeout macro)

- clk  input  1  single clock for both buses
- rst  input  1  reset, synchronous, active-high
- s_axil  AXI4Lite.slave  ADDR_WIDTH/DATA_WIDTH  AXI4-Lite responder port
- m_reg  REG_BUS.master  ADDR_WIDTH/DATA_WIDTH  register-bus initiator port

## Operation
- Write FSM: W_IDLE -> W_ISSUE -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1 until AW captured, wready=1 until W captured; AW and W accepted in any order or same cycle.
  - Both captured -> W_ISSUE: wren=1 for exactly one cycle with waddr = awaddr with low log2(DATA_WIDTH/8) bits cleared, wdata, wstrb as received.
  - W_RESP: bvalid=1, bresp=2'b00; hold until bready; then W_IDLE.
- Read FSM: R_IDLE -> R_ISSUE -> R_WAIT -> R_RESP -> R_IDLE.
  - R_IDLE: arready=1; on handshake capture aligned araddr.
  - R_ISSUE: rden=1 for one cycle, raddr stable from this cycle until rvld.
  - R_WAIT: on rvld capture rdata, go R_RESP. rvld in R_ISSUE cycle is also accepted (skip R_WAIT).
  - R_RESP: rvalid=1, rresp=2'b00, rdata held; hold until rready; then R_IDLE.
- rvld outside R_ISSUE/R_WAIT ignored.
- awprot/arprot ignored. All addresses forwarded; decode is downstream.
- Write and read FSMs fully independent; simultaneous wren and rden permitted.

## Timing
- All outputs registered. Reset values: awready/wready/arready 0, bvalid/rvalid 0, bresp/rresp 0, rdata 0, wren/rden 0, waddr/wdata/wstrb/raddr 0. Ready signals rise the first cycle after rst deasserts.
- Write: last of AW/W handshake at cycle N -> wren at N+1 -> bvalid at N+2. awready/wready drop the cycle after their own handshake, reassert the cycle after B handshake.
- Read: AR handshake at N -> rden at N+1 -> rvld at M -> rvalid at M+1. arready low from N+1 until the cycle after R handshake.
- bvalid/rvalid, bresp/rresp, rdata stable while waiting on bready/rready (AXI rule, no drop).
- Back-to-back: max throughput one write per 3 cycles, one read per 3 cycles + downstream latency.
- rst mid-transaction: both FSMs to IDLE in the next cycle, pending transaction dropped, no response issued, all outputs to reset values.

## Configuration
- AXIL_RD_TIMEOUT_EN defined: 8-bit-or-wider counter runs in R_ISSUE/R_WAIT; on reaching RD_TIMEOUT cycles without rvld -> R_RESP with rresp=2'b10 (SLVERR), rdata=32'hDEAD_BEEF (replicated for 64-bit); late rvld for that read ignored.
- Undefined: R_WAIT waits indefinitely; counter and error path not present; rresp always 2'b00.

## Test plan
- AW and W same cycle, awaddr=0x0000_0013, wdata=0xA5A5_1234, wstrb=0xF -> one-cycle wren, waddr=0x10, wdata/wstrb match; bvalid one cycle later, bresp=0.
- W two cycles before AW, bready held low 5 cycles -> wren only after AW; bvalid held 5 cycles stable, awready/wready stay low until B handshake.
- Read araddr=0x24, slave returns rvld 3 cycles after rden with rdata=0x1122_3344 -> rvalid at rvld+1, rdata=0x1122_3344, rresp=0; rvld same cycle as rden -> rvalid next cycle.
- Concurrent write 0x08 and read 0x0C with rready low 4 cycles -> wren and rden in same cycle, responses independent and stable.
- Assert rst for 1 cycle while in R_WAIT and W_RESP -> bvalid/rvalid drop next cycle, no response after; next read completes normally.
- With AXIL_RD_TIMEOUT_EN, RD_TIMEOUT=16, no rvld -> rvalid 16 cycles after rden, rresp=2'b10, rdata=0xDEADBEEF; late rvld ignored.
